// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle between an operand producer and serial_adder.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; no buffering here.
// Ports (signals): in_valid/in_ready, a, b, cin, sub on the operand side;
//                  out_valid/out_ready, sum, cout, ovf on the result side.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer/consumer side (testbench or upstream datapath).
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract of WIDTH-bit operands through one DIGIT-bit ripple slice.
// Latency: operand accepted at edge E0, out_valid rises after edge E0+WIDTH/DIGIT.
// Backpressure: one operation in flight; in_ready low from accept until result handshake.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the operand
//        handshake (in_valid/in_ready, a, b, cin, sub) and the result handshake
//        (out_valid/out_ready, sum, cout, ovf).
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;     // partial result, filled from the MSB side
    logic [WIDTH-1:0] sum_q, sum_d;     // published result, only updated on completion
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [SW-1:0]    step_q, step_d;

    logic [DIGIT:0]   slice;
    logic             cmsb;
    logic [WIDTH-1:0] res_shift;
    logic             last_step;

    assign slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

    // Carry into the top bit of the slice recovered as a ^ b ^ s of that bit;
    // on the last step this is the carry into the operand MSB.
    assign cmsb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];

    // Written as a shift of the concatenation so DIGIT == WIDTH needs no special case.
    assign res_shift = WIDTH'({slice[DIGIT-1:0], res_q} >> DIGIT);

    assign last_step = (step_q == SW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        step_d  = step_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction as A + ~B + 1; cin is deliberately ignored.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift;
                carry_d = slice[DIGIT];
                step_d  = step_q + SW'(1);
                if (last_step) begin
                    sum_d   = res_shift;
                    cout_d  = slice[DIGIT];
                    ovf_d   = cmsb ^ slice[DIGIT];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is gated by rst_n so it drops the moment reset asserts.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule
